// File: rtl/checkpoint_seq_monitor.sv
// Watches a firmware-driven progress code field and checks that NUM_CKPT expected
// codes arrive in order, reporting per-checkpoint hits and a final pass/fail verdict.
module checkpoint_seq_monitor #(
  parameter int                DATA_W        = 16,
  parameter int                NUM_CKPT      = 4,
  parameter int                CNT_W         = 32,
  parameter longint unsigned   TIMEOUT       = 250000,
  parameter int                STABLE_CYCLES = 1,
  parameter int                STRICT        = 0,
  localparam int               IDX_W         = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         start,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [NUM_CKPT*DATA_W-1:0]   exp_codes,
  input  logic [DATA_W-1:0]            exp_mask,
  output logic                         busy,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic [CNT_W-1:0]             hit_time,
  output logic [IDX_W-1:0]             ckpt_idx,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code
);

  localparam int                RUN_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CKPT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_t;

  state_t              state;
  logic [DATA_W-1:0]   d_q;
  logic [RUN_W-1:0]    run_len;
  logic [CNT_W-1:0]    cycle_cnt;
  logic                consumed;

  logic cur_match, later_match, qual, hit_now, final_hit, order_viol, timed_out;

  // Match the sampled code against every checkpoint; split into "awaited" and "ahead".
  always_comb begin
    cur_match   = 1'b0;
    later_match = 1'b0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (((d_q ^ exp_codes[k*DATA_W +: DATA_W]) & exp_mask) == '0) begin
        if (IDX_W'(k) == ckpt_idx) cur_match = 1'b1;
        if (IDX_W'(k) > ckpt_idx)  later_match = 1'b1;
      end
    end
    qual       = (state == ST_ARMED) && (run_len >= RUN_MAX) && !consumed;
    hit_now    = qual && cur_match;
    final_hit  = hit_now && (ckpt_idx == IDX_LAST);
    order_viol = (STRICT != 0) && qual && !cur_match && later_match;
    timed_out  = (state == ST_ARMED) && (cycle_cnt == TO_LAST);
  end

  assign busy = (state == ST_ARMED);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      d_q       <= '0;
      run_len   <= '0;
      cycle_cnt <= '0;
      consumed  <= 1'b0;
      ckpt_idx  <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      hit_time  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'b00;
    end else begin
      d_q <= data_in;
      if (data_in != d_q)       run_len <= RUN_W'(1);
      else if (run_len < RUN_MAX) run_len <= run_len + RUN_W'(1);
      hit <= 1'b0;

      case (state)
        ST_ARMED: begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
          if (hit_now) begin
            hit      <= 1'b1;
            hit_idx  <= ckpt_idx;
            hit_time <= cycle_cnt;
            consumed <= 1'b1;
            if (final_hit) begin
              state <= ST_PASS;
              pass  <= 1'b1;
              done  <= 1'b1;
            end else begin
              ckpt_idx <= ckpt_idx + IDX_W'(1);
            end
          end
          // A final hit on the timeout cycle wins; a violation on it reports order.
          if (order_viol) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_code <= 2'b10;
          end else if (timed_out && !final_hit) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_code <= 2'b01;
          end
        end
        default: begin
          if (start) begin
            state     <= ST_ARMED;
            ckpt_idx  <= '0;
            cycle_cnt <= '0;
            consumed  <= 1'b0;
            hit_idx   <= '0;
            hit_time  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'b00;
          end
        end
      endcase

      // A new value on the field always re-enables hitting.
      if (data_in != d_q) consumed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: three configurations share one stimulus stream
// and are checked every cycle against a behavioural model, plus directed literals.
module tb_checkpoint_seq_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [63:0] exp_codes;
  logic [15:0] exp_mask;

  logic        busy_o[3], hit_o[3], done_o[3], pass_o[3], fail_o[3];
  logic [1:0]  hit_idx_o[3], ckpt_o[3], fcode_o[3];
  logic [31:0] htime_o[3];

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 0;

  // model state: 0 idle, 1 armed, 2 pass, 3 fail
  int          m_state[3], m_run[3], m_cnt[3], m_idx[3], m_hidx[3], m_htime[3], m_fcode[3];
  logic [15:0] m_dq[3];
  bit          m_cons[3], m_hit[3], m_done[3], m_pass[3], m_fail[3];

  int          hit_cnt[3] = '{0, 0, 0};
  int          hq_idx[$];
  int          hq_time[$];
  logic [15:0] codes[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    checkpoint_seq_monitor #(
      .DATA_W(16), .NUM_CKPT(4), .CNT_W(32), .TIMEOUT(100),
      .STABLE_CYCLES((g == 1) ? 3 : 1), .STRICT((g == 0) ? 0 : 1)
    ) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .data_in(data_in),
      .exp_codes(exp_codes), .exp_mask(exp_mask),
      .busy(busy_o[g]), .hit(hit_o[g]), .hit_idx(hit_idx_o[g]), .hit_time(htime_o[g]),
      .ckpt_idx(ckpt_o[g]), .done(done_o[g]), .pass(pass_o[g]), .fail(fail_o[g]),
      .fail_code(fcode_o[g])
    );
  end

  function automatic int ps(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic bit pstrict(input int i);
    return i != 0;
  endfunction

  function automatic bit cm(input logic [15:0] v, input int k);
    return ((v ^ exp_codes[k*16 +: 16]) & exp_mask) == 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    bit q, cur, ahead, changed;
    int old_cnt;
    if (rst) begin
      m_state[i] = 0; m_dq[i] = 16'h0; m_run[i] = 0; m_cnt[i] = 0; m_cons[i] = 0;
      m_idx[i] = 0; m_hit[i] = 0; m_hidx[i] = 0; m_htime[i] = 0;
      m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_fcode[i] = 0;
    end else begin
      changed = (data_in != m_dq[i]);
      q       = (m_state[i] == 1) && (m_run[i] >= ps(i)) && !m_cons[i];
      cur     = q && cm(m_dq[i], m_idx[i]);
      ahead   = 0;
      for (int j = m_idx[i] + 1; j < 4; j++) if (cm(m_dq[i], j)) ahead = 1;
      old_cnt  = m_cnt[i];
      m_hit[i] = 0;
      if (m_state[i] != 1) begin
        if (start) begin
          m_state[i] = 1; m_cnt[i] = 0; m_idx[i] = 0; m_cons[i] = 0;
          m_hidx[i] = 0; m_htime[i] = 0;
          m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_fcode[i] = 0;
        end
      end else begin
        m_cnt[i] = old_cnt + 1;
        if (cur) begin
          m_hit[i] = 1; m_hidx[i] = m_idx[i]; m_htime[i] = old_cnt; m_cons[i] = 1;
          if (m_idx[i] == 3) begin
            m_state[i] = 2; m_pass[i] = 1; m_done[i] = 1;
          end else begin
            m_idx[i]++;
          end
        end
        if (pstrict(i) && q && !cur && ahead) begin
          m_state[i] = 3; m_fail[i] = 1; m_done[i] = 1; m_fcode[i] = 2;
        end else if (m_state[i] == 1 && old_cnt == 99) begin
          m_state[i] = 3; m_fail[i] = 1; m_done[i] = 1; m_fcode[i] = 1;
        end
      end
      m_dq[i]  = data_in;
      m_run[i] = changed ? 1 : ((m_run[i] + 1 > ps(i)) ? ps(i) : m_run[i] + 1);
      if (changed) m_cons[i] = 0;
    end
  endtask

  always @(posedge clk) for (int i = 0; i < 3; i++) model_step(i);

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", i),     busy_o[i],    m_state[i] == 1);
        chk($sformatf("hit%0d", i),      hit_o[i],     m_hit[i]);
        chk($sformatf("hit_idx%0d", i),  hit_idx_o[i], m_hidx[i]);
        chk($sformatf("hit_time%0d", i), htime_o[i],   m_htime[i]);
        chk($sformatf("ckpt_idx%0d", i), ckpt_o[i],    m_idx[i]);
        chk($sformatf("done%0d", i),     done_o[i],    m_done[i]);
        chk($sformatf("pass%0d", i),     pass_o[i],    m_pass[i]);
        chk($sformatf("fail%0d", i),     fail_o[i],    m_fail[i]);
        chk($sformatf("fail_code%0d", i), fcode_o[i],  m_fcode[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (hit_o[i] === 1'b1) begin
        hit_cnt[i]++;
        if (i == 0) begin
          hq_idx.push_back(int'(hit_idx_o[0]));
          hq_time.push_back(int'(htime_o[0]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic set_exp(input logic [15:0] k3, k2, k1, k0);
    codes[3] = k3; codes[2] = k2; codes[1] = k1; codes[0] = k0;
    exp_codes = {k3, k2, k1, k0};
  endtask

  initial begin
    int b, h;
    logic [15:0] seq[4];
    rst = 1'b1; start = 1'b0; data_in = 16'h0000; exp_mask = 16'hFFFF;
    set_exp(16'hAB51, 16'hAB62, 16'hAB61, 16'hAB40);
    step(2);
    chk_en = 1;
    step(1);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_done", done_o[0], 0);
    chk("rst_ckpt", ckpt_o[0], 0);
    chk("rst_fail_code", fcode_o[0], 0);
    rst = 1'b0;
    step(2);

    // full ordered pass
    seq[0] = 16'hAB40; seq[1] = 16'hAB61; seq[2] = 16'hAB62; seq[3] = 16'hAB51;
    b = hq_idx.size();
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      data_in = seq[c];
      step(10);
    end
    chk("pass_hits", hq_idx.size(), b + 4);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pass_idx%0d", c), hq_idx[b+c], c);
      chk($sformatf("pass_time%0d", c), hq_time[b+c], 1 + 10 * c);
    end
    chk("pass_pass", pass_o[0], 1);
    chk("pass_done", done_o[0], 1);
    chk("pass_busy", busy_o[0], 0);

    // timeout
    data_in = 16'h0000;
    step(2);
    b = hq_idx.size();
    pulse_start();
    data_in = 16'hAB40;
    step(99);
    chk("to_early_fail", fail_o[0], 0);
    chk("to_early_busy", busy_o[0], 1);
    step(1);
    chk("to_fail", fail_o[0], 1);
    chk("to_code", fcode_o[0], 2'b01);
    chk("to_ckpt", ckpt_o[0], 1);
    chk("to_hits", hq_idx.size(), b + 1);
    chk("to_hit_idx", hq_idx[b], 0);

    // strict ordering (inst2 strict, inst0 relaxed)
    data_in = 16'h0000;
    step(2);
    h = hit_cnt[2];
    pulse_start();
    data_in = 16'hAB61;
    step(5);
    chk("strict_fail", fail_o[2], 1);
    chk("strict_code", fcode_o[2], 2'b10);
    chk("strict_nohit", hit_cnt[2], h);
    chk("relax_fail", fail_o[0], 0);
    chk("relax_busy", busy_o[0], 1);
    b = hq_idx.size();
    data_in = 16'hAB40;
    step(3);
    chk("relax_hits", hq_idx.size(), b + 1);
    chk("relax_idx", hq_idx[b], 0);

    // glitch filter (inst1, STABLE_CYCLES=3)
    data_in = 16'h0000;
    step(4);
    h = hit_cnt[1];
    pulse_start();
    data_in = 16'hAB40;
    step(2);
    data_in = 16'h0000;
    step(6);
    chk("glitch_nohit", hit_cnt[1], h);
    data_in = 16'hAB40;
    step(3);
    chk("glitch_early", hit_o[1], 0);
    step(1);
    chk("glitch_hit", hit_o[1], 1);
    chk("glitch_idx", hit_idx_o[1], 0);

    // duplicate expected codes
    pulse_rst();
    set_exp(16'hAB40, 16'hAB40, 16'hAB40, 16'hAB40);
    data_in = 16'h0000;
    step(1);
    b = hq_idx.size();
    pulse_start();
    data_in = 16'hAB40;
    step(10);
    chk("dup_one_hit", hq_idx.size(), b + 1);
    chk("dup_ckpt", ckpt_o[0], 1);
    repeat (3) begin
      data_in = 16'h0000;
      step(2);
      data_in = 16'hAB40;
      step(3);
    end
    chk("dup_hits", hq_idx.size(), b + 4);
    chk("dup_pass", pass_o[0], 1);

    // compare mask
    pulse_rst();
    set_exp(16'h1111, 16'h2222, 16'h3333, 16'hAB00);
    exp_mask = 16'hFF00;
    data_in = 16'h0000;
    step(1);
    b = hq_idx.size();
    pulse_start();
    data_in = 16'hAB7F;
    step(3);
    chk("mask_hits", hq_idx.size(), b + 1);
    chk("mask_idx", hq_idx[b], 0);
    chk("mask_ckpt", ckpt_o[0], 1);
    exp_mask = 16'hFFFF;

    // reset mid-run and re-arm
    pulse_rst();
    set_exp(16'hAB51, 16'hAB62, 16'hAB61, 16'hAB40);
    data_in = 16'h0000;
    step(1);
    pulse_start();
    data_in = 16'hAB40;
    step(3);
    data_in = 16'hAB61;
    step(3);
    chk("rr_two_hits", ckpt_o[0], 2);
    pulse_rst();
    chk("rr_busy", busy_o[0], 0);
    chk("rr_hit", hit_o[0], 0);
    chk("rr_hit_idx", hit_idx_o[0], 0);
    chk("rr_hit_time", htime_o[0], 0);
    chk("rr_ckpt", ckpt_o[0], 0);
    chk("rr_done", done_o[0], 0);
    chk("rr_pass", pass_o[0], 0);
    chk("rr_fail", fail_o[0], 0);
    chk("rr_code", fcode_o[0], 0);
    pulse_start();
    data_in = 16'hAB40;
    step(3);
    chk("rr_rearm_ckpt", ckpt_o[0], 1);
    pulse_start();
    chk("rr_ign_busy", busy_o[0], 1);
    chk("rr_ign_ckpt", ckpt_o[0], 1);
    data_in = 16'hAB61; step(3);
    data_in = 16'hAB62; step(3);
    data_in = 16'hAB51; step(3);
    chk("rr_pass2", pass_o[0], 1);
    pulse_start();
    chk("rr_new_busy", busy_o[0], 1);
    chk("rr_new_pass", pass_o[0], 0);
    chk("rr_new_done", done_o[0], 0);
    chk("rr_new_ckpt", ckpt_o[0], 0);

    // randomized traffic, model-checked every cycle
    for (int it = 0; it < 500; it++) begin
      int r;
      if (it % 60 == 0) begin
        for (int k = 0; k < 4; k++) begin
          r = $urandom_range(0, 5);
          codes[k] = (r == 0) ? 16'hAB40 : (r == 1) ? 16'hAB61 : (r == 2) ? 16'hAB62 :
                     (r == 3) ? 16'hAB51 : 16'($urandom);
        end
        exp_codes = {codes[3], codes[2], codes[1], codes[0]};
      end
      exp_mask = ($urandom_range(0, 15) == 0) ? 16'hFF00 : 16'hFFFF;
      r = $urandom_range(0, 9);
      data_in = (r < 6) ? codes[r % 4] : (r < 8) ? 16'h0000 : 16'($urandom);
      start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(1);
      start = 1'b0;
      rst = 1'b0;
      step($urandom_range(0, 4));
    end
    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
